result_collector: RTL
=====================

# result_collector

Drains the bottom edge of the weight-stationary `pe_array`. It is the output-side counterpart of the skewed activation feeder. Column j of a result vector leaves the array j cycles after column 0. The collector re-aligns the columns with per-column delay lines, tags each aligned vector, and buffers it in a small FIFO behind a valid/ready handshake. The array cannot stall, so the block exports a free-entry credit that the feeder uses to throttle tile issue.

## Interface
- `ARRAY_SIZE`, 2: columns in the PE array; entries per result vector.
- `ACCUMULATOR_DATA_WIDTH`, 16: width of each column result.
- `FIFO_DEPTH`, 4: aligned vectors buffered; power of two, ≥ 2.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `results`  in  `[ACCUMULATOR_DATA_WIDTH-1:0] [ARRAY_SIZE]`  bottom-row accumulators from `pe_array`.
- `in_valid`  in  1  `results[0]` holds column 0 of a new vector this cycle.
- `in_last`  in  1  qualifies `in_valid`; vector is the last of a tile.
- `out_data`  out  `[ACCUMULATOR_DATA_WIDTH-1:0] [ARRAY_SIZE]`  aligned head vector.
- `out_valid`  out  1  FIFO non-empty.
- `out_last`  out  1  last tag of head vector.
- `out_ready`  in  1  consumer accepts head when `out_valid` is high.
- `credit`  out  `$clog2(FIFO_DEPTH+1)`  free FIFO entries.
- `overflow`  out  1  sticky; an aligned vector was dropped.

## Operation
- Capture: `in_valid` in cycle t opens a vector. Column j is sampled from `results[j]` in cycle t+j.
- Alignment:
  - Column j passes through `ARRAY_SIZE-1-j` register stages. Column `ARRAY_SIZE-1` is unregistered.
  - `in_valid`/`in_last` pass through `ARRAY_SIZE-1` stages.
  - The aligned vector is complete in cycle t+`ARRAY_SIZE`-1.
- Vectors may be issued on consecutive cycles. Overlapping skew windows must not corrupt each other.
- Push: the aligned vector is written to the FIFO tail on the edge ending cycle t+`ARRAY_SIZE`-1.
- Pop: on an edge where `out_valid && out_ready`.
- Full push:
  - If full and no pop occurs that edge, the vector is discarded and `overflow` sets.
  - If full and a pop occurs the same edge, the push is accepted and no overflow is flagged.
- Empty pop: `out_ready` while empty has no effect.
- `credit` = `FIFO_DEPTH` − occupancy. It is registered and updates on the same edge as push/pop.
- `out_data`/`out_last` present the head entry when `out_valid` is high and all-zero otherwise.
- Data passes unchanged: no sign extension, truncation, or arithmetic.
- `overflow` clears only on `rst`.

## Timing
- Reset (synchronous, takes effect at the edge):
  - Alignment-pipeline valid bits cleared.
  - FIFO pointers cleared.
  - `out_valid`=0, `out_last`=0, `out_data`=0, `credit`=`FIFO_DEPTH`, `overflow`=0.
- Reset mid-flight: all partially aligned vectors are discarded and never appear at the output.
- Latency: `in_valid` at cycle t gives `out_valid` at t+`ARRAY_SIZE` when the FIFO was empty. There is no FIFO bypass.
- Throughput: one vector per cycle sustained when `out_ready` is held high.
- `in_valid` during `rst` is ignored.

## Structure
- Shared package `pe_array_pkg`:
  - default constants `ARRAY_SIZE`, `COMPUTE_DATA_WIDTH`, `ACCUMULATOR_DATA_WIDTH`, `RESULT_FIFO_DEPTH`;
  - helper function for credit/pointer widths.
- Sub-module `result_fifo`:
  - synchronous FIFO, parameterized on width and depth;
  - ports: push, pop, full/empty, occupancy;
  - entry = `{last, vector}`.
- Alignment delay lines: a triangular generate block in `result_collector`.

## Test plan
All scenarios use `ARRAY_SIZE`=2, width 16, `FIFO_DEPTH`=4.
- Single vector: `in_valid` in cycle 10 with `results[0]`=0x0011; `results[1]`=0x0022 in cycle 11 → `out_valid` in cycle 12 with `out_data`={0x0011,0x0022}; `credit` 4→3 at cycle 12; pop returns it to 4.
- Fill and drop:
  - Stimulus: `out_ready`=0; 5 back-to-back vectors with values 1..5.
  - Expected: `credit` reaches 0; vector 5 dropped; `overflow`=1 and stays 1.
  - Drain: yields 1,2,3,4 in order.
- Full with simultaneous pop: FIFO full; aligned push and pop land on the same edge → push accepted, `overflow`=0, `credit` stays 0.
- Last tag: 4 vectors with `in_last` only on the 3rd → `out_last`=1 only while the 3rd is at the head.
- Reset mid-flight: `in_valid` at cycle t, `rst` at t+1 → no `out_valid` ever; `credit`=4, `overflow`=0.
- Streaming:
  - Stimulus: `out_ready`=1; 8 consecutive vectors with `results[j]`=16·k+j.
  - Expected: outputs in order, one per cycle, each 2 cycles after its `in_valid`; `credit` never below 3.

Source files
------------

// File: rtl/pe_array_pkg.sv
// Shared constants and width helpers for the PE array and its edge blocks.
package pe_array_pkg;

    localparam int ARRAY_SIZE             = 2;
    localparam int COMPUTE_DATA_WIDTH     = 8;
    localparam int ACCUMULATOR_DATA_WIDTH = 16;
    localparam int RESULT_FIFO_DEPTH      = 4;

    // Bits needed to hold an occupancy or credit value in 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/result_collector_if.sv
// Bundle between the PE array bottom edge, the result collector and its consumer.
//
// Handshake: a head vector transfers on every rising edge where out_valid and
// out_ready are both high; out_valid never waits on out_ready, and out_data /
// out_last hold steady while out_valid is high and out_ready is low. The input
// side (in_valid/results) has no back-pressure: the array cannot stall, so the
// producer throttles itself from credit.
interface result_collector_if #(
    parameter int ARRAY_SIZE             = pe_array_pkg::ARRAY_SIZE,
    parameter int ACCUMULATOR_DATA_WIDTH = pe_array_pkg::ACCUMULATOR_DATA_WIDTH,
    parameter int FIFO_DEPTH             = pe_array_pkg::RESULT_FIFO_DEPTH
);
    localparam int CREDIT_W = pe_array_pkg::count_width(FIFO_DEPTH);

    logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0] results;
    logic                                              in_valid;
    logic                                              in_last;
    logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0] out_data;
    logic                                              out_valid;
    logic                                              out_last;
    logic                                              out_ready;
    logic [CREDIT_W-1:0]                               credit;
    logic                                              overflow;

    // Collector side.
    modport slave (
        input  results, in_valid, in_last, out_ready,
        output out_data, out_valid, out_last, credit, overflow
    );

    // Array / consumer side.
    modport master (
        output results, in_valid, in_last, out_ready,
        input  out_data, out_valid, out_last, credit, overflow
    );

endinterface

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding {last, vector} entries. A push while full is
// accepted only when a pop happens on the same edge; a pop while empty is ignored.
module result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      push_i,
    input  logic [WIDTH-1:0]                          push_data_i,
    input  logic                                      pop_i,
    output logic [WIDTH-1:0]                          head_o,
    output logic                                      full_o,
    output logic                                      empty_o,
    output logic [pe_array_pkg::count_width(DEPTH)-1:0] count_o
);
    import pe_array_pkg::*;

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between rd and wr pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/result_collector.sv
// De-skews the bottom edge of the PE array: column j arrives j cycles after
// column 0, so it is delayed by ARRAY_SIZE-1-j stages until the whole vector
// lines up, then the tagged vector is pushed into a small FIFO. Assumes
// ARRAY_SIZE >= 2.
module result_collector #(
    parameter int ARRAY_SIZE             = pe_array_pkg::ARRAY_SIZE,
    parameter int ACCUMULATOR_DATA_WIDTH = pe_array_pkg::ACCUMULATOR_DATA_WIDTH,
    parameter int FIFO_DEPTH             = pe_array_pkg::RESULT_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    result_collector_if.slave bus
);
    import pe_array_pkg::*;

    localparam int W        = ACCUMULATOR_DATA_WIDTH;
    localparam int VEC_W    = ARRAY_SIZE * W;
    localparam int ENTRY_W  = VEC_W + 1;
    localparam int CREDIT_W = count_width(FIFO_DEPTH);

    logic [W-1:0]                  aligned_col [ARRAY_SIZE];
    logic [ARRAY_SIZE-1:0][W-1:0]  aligned_vec;
    logic [ARRAY_SIZE-2:0]         vld_q;
    logic [ARRAY_SIZE-2:0]         last_q;
    logic                          aligned_valid;
    logic                          aligned_last;

    logic                          fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]            fifo_head;
    logic [CREDIT_W-1:0]           fifo_count;
    logic                          push, pop, drop;

    logic [CREDIT_W-1:0]           credit_q, credit_d;
    logic                          overflow_q, overflow_d;

    // Triangular delay lines: column j gets ARRAY_SIZE-1-j stages, the last column none.
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
        if (j == ARRAY_SIZE - 1) begin : g_direct
            assign aligned_col[j] = bus.results[j];
        end else begin : g_delay
            localparam int STAGES = ARRAY_SIZE - 1 - j;
            logic [W-1:0] stage_q [STAGES];

            // Shift column j one stage per cycle; no reset needed, validity rides in vld_q.
            always_ff @(posedge clk) begin
                stage_q[0] <= bus.results[j];
                for (int k = 1; k < STAGES; k++) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end

            assign aligned_col[j] = stage_q[STAGES-1];
        end
    end

    // Valid/last travel alongside column 0; clearing them on reset discards vectors in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q[0]  <= bus.in_valid;
            last_q[0] <= bus.in_last & bus.in_valid;
            for (int k = 1; k < ARRAY_SIZE - 1; k++) begin
                vld_q[k]  <= vld_q[k-1];
                last_q[k] <= last_q[k-1];
            end
        end
    end

    assign aligned_valid = vld_q[ARRAY_SIZE-2];
    assign aligned_last  = last_q[ARRAY_SIZE-2];

    // Pack the aligned columns into one vector, column j in slot j.
    always_comb begin
        aligned_vec = '0;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            aligned_vec[j] = aligned_col[j];
        end
    end

    // A full FIFO still takes the vector when the head leaves on the same edge.
    assign pop  = ~fifo_empty & bus.out_ready;
    assign push = aligned_valid & (~fifo_full | pop);
    assign drop = aligned_valid & fifo_full & ~pop;

    result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({aligned_last, aligned_vec}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Credit tracks free entries after this edge's push/pop; overflow is sticky.
    always_comb begin
        credit_d = CREDIT_W'(FIFO_DEPTH) - fifo_count;
        if (push && !pop) begin
            credit_d = credit_d - CREDIT_W'(1);
        end else if (pop && !push) begin
            credit_d = credit_d + CREDIT_W'(1);
        end
        overflow_d = overflow_q | drop;
    end

    // Credit and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q   <= CREDIT_W'(FIFO_DEPTH);
            overflow_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.out_valid = ~fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : fifo_head[VEC_W-1:0];
    assign bus.out_last  = ~fifo_empty & fifo_head[VEC_W];
    assign bus.credit    = credit_q;
    assign bus.overflow  = overflow_q;

endmodule
